// File: rtl/led_pkg.sv
// LED register map and led_data field layout shared by the LED peripheral and the PWM driver.
package led_pkg;

    localparam logic [31:0] LED_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] LED_DATA = 32'h0000_0000;

    localparam int unsigned DUTY_W    = 8;
    localparam int unsigned R_LSB     = 0;
    localparam int unsigned G_LSB     = 8;
    localparam int unsigned B_LSB     = 16;
    localparam int unsigned BLINK_LSB = 24;
    localparam int unsigned BLINK_W   = 4;
    localparam int unsigned EN_BIT    = 31;

    localparam logic [7:0] PWM_MAX = 8'd254;

    typedef struct packed {
        logic                 en;
        logic [BLINK_W-1:0]   blink_sel;
        logic [DUTY_W-1:0]    duty_b;
        logic [DUTY_W-1:0]    duty_g;
        logic [DUTY_W-1:0]    duty_r;
    } led_shadow_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM colour channel: compares the shared step counter with its shadow duty and
// registers the result onto the pin in the configured polarity.
module led_pwm_channel #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty,
    input  logic [7:0] pwm_cnt,
    input  logic       blink_on,
    input  logic       en,
    output logic       led
);

    logic on;
    logic led_q;

    always_comb begin
        on = en & blink_on & (pwm_cnt < duty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= ACTIVE_LOW;
        end else begin
            led_q <= on ^ ACTIVE_LOW;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pwm.sv
// RGB LED PWM driver: prescaled 255-step period, double-buffered duties and blink control
// loaded from led_data only at period boundaries.
module led_pwm
    import led_pkg::*;
#(
    parameter int unsigned PRESCALE   = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] led_data,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        period_start
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [15:0]     per_cnt_q, per_cnt_d;
    led_shadow_t     shadow_q, shadow_d;
    logic            init_q, init_d;
    logic            period_start_q, period_start_d;

    logic tick;
    logic wrap;
    logic boundary;
    logic blink_on;
    logic unused_reserved;

    assign unused_reserved = ^led_data[30:28];

    always_comb begin
        tick     = (pre_cnt_q == PreW'(PRESCALE - 1));
        wrap     = tick && (pwm_cnt_q == PWM_MAX);
        // init forces a load on the first tick so a fresh reset does not sit dark for a period
        boundary = tick && (wrap || init_q);

        pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d      = pwm_cnt_q;
        per_cnt_d      = per_cnt_q;
        shadow_d       = shadow_q;
        init_d         = init_q;
        period_start_d = wrap;

        if (tick) begin
            pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
        end

        if (boundary) begin
            shadow_d.en        = led_data[EN_BIT];
            shadow_d.blink_sel = led_data[BLINK_LSB +: BLINK_W];
            shadow_d.duty_b    = led_data[B_LSB +: DUTY_W];
            shadow_d.duty_g    = led_data[G_LSB +: DUTY_W];
            shadow_d.duty_r    = led_data[R_LSB +: DUTY_W];
            init_d             = 1'b0;
            if (!init_q) begin
                per_cnt_d = per_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            per_cnt_q      <= '0;
            shadow_q       <= '0;
            init_q         <= 1'b1;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            per_cnt_q      <= per_cnt_d;
            shadow_q       <= shadow_d;
            init_q         <= init_d;
            period_start_q <= period_start_d;
        end
    end

    always_comb begin
        if (shadow_q.blink_sel == '0) begin
            blink_on = 1'b1;
        end else begin
            blink_on = ~per_cnt_q[shadow_q.blink_sel - 4'd1];
        end
    end

    assign period_start = period_start_q;

    led_pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .clk      (clk),
        .rst      (rst),
        .duty     (shadow_q.duty_r),
        .pwm_cnt  (pwm_cnt_q),
        .blink_on (blink_on),
        .en       (shadow_q.en),
        .led      (led_r)
    );

    led_pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .clk      (clk),
        .rst      (rst),
        .duty     (shadow_q.duty_g),
        .pwm_cnt  (pwm_cnt_q),
        .blink_on (blink_on),
        .en       (shadow_q.en),
        .led      (led_g)
    );

    led_pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .clk      (clk),
        .rst      (rst),
        .duty     (shadow_q.duty_b),
        .pwm_cnt  (pwm_cnt_q),
        .blink_on (blink_on),
        .en       (shadow_q.en),
        .led      (led_b)
    );

endmodule

// File: tb/tb_led_pwm.sv
// Bench for led_pwm: two instances (PRESCALE=1/ACTIVE_LOW=1 and PRESCALE=3/ACTIVE_LOW=0)
// checked every cycle against a timing model derived from the edge count since reset.
module tb_led_pwm;

    logic        clk;
    logic        rst;
    logic [31:0] led_data;
    logic        a_r, a_g, a_b, a_ps;
    logic        b_r, b_g, b_b, b_ps;

    int          tests;
    int          fails;
    int          n;
    logic [31:0] sh_a;
    logic [31:0] sh_b;
    int          a_r_low, a_g_low, a_b_low, a_ps_cnt, b_r_high;

    led_pwm #(.PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .led_data     (led_data),
        .led_r        (a_r),
        .led_g        (a_g),
        .led_b        (a_b),
        .period_start (a_ps)
    );

    led_pwm #(.PRESCALE(3), .ACTIVE_LOW(1'b0)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .led_data     (led_data),
        .led_r        (b_r),
        .led_g        (b_g),
        .led_b        (b_b),
        .period_start (b_ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pins and period_start after edge n, given the shadow word in force before that edge.
    function automatic logic [3:0] model_out(input int k_edge, input logic [31:0] sh,
                                             input int p, input bit al);
        int          k;
        int          pwm;
        logic [15:0] per;
        logic [3:0]  sel;
        logic        blink, r, g, b, ps;
        k     = (k_edge - 1) / p;
        pwm   = k % 255;
        per   = 16'(k / 255);
        sel   = sh[27:24];
        blink = (sel == 4'd0) ? 1'b1 : !per[sel - 4'd1];
        r     = sh[31] & blink & (pwm < int'(sh[7:0]));
        g     = sh[31] & blink & (pwm < int'(sh[15:8]));
        b     = sh[31] & blink & (pwm < int'(sh[23:16]));
        ps    = (k_edge % p == 0) && ((k_edge / p) % 255 == 0);
        return {r ^ al, g ^ al, b ^ al, ps};
    endfunction

    function automatic bit is_boundary(input int k_edge, input int p);
        return (k_edge % p == 0) && ((k_edge / p == 1) || ((k_edge / p) % 255 == 0));
    endfunction

    task automatic clear_counts();
        a_r_low  = 0;
        a_g_low  = 0;
        a_b_low  = 0;
        a_ps_cnt = 0;
        b_r_high = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) begin
            check_eq("rst_hold_a", {a_r, a_g, a_b, a_ps}, 4'b1110);
            check_eq("rst_hold_b", {b_r, b_g, b_b, b_ps}, 4'b0000);
        end else begin
            n++;
            check_eq("pins_a", {a_r, a_g, a_b, a_ps}, model_out(n, sh_a, 1, 1'b1));
            check_eq("pins_b", {b_r, b_g, b_b, b_ps}, model_out(n, sh_b, 3, 1'b0));
            if (!a_r) a_r_low++;
            if (!a_g) a_g_low++;
            if (!a_b) a_b_low++;
            if (a_ps) a_ps_cnt++;
            if (b_r)  b_r_high++;
            if (is_boundary(n, 1)) sh_a = led_data;
            if (is_boundary(n, 3)) sh_b = led_data;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic do_reset(input logic [31:0] d);
        @(negedge clk);
        rst      = 1'b0;
        led_data = d;
        #1;
        check_eq("rst_async_a", {a_r, a_g, a_b, a_ps}, 4'b1110);
        check_eq("rst_async_b", {b_r, b_g, b_b, b_ps}, 4'b0000);
        n    = 0;
        sh_a = '0;
        sh_b = '0;
        run(3);
        @(negedge clk);
        rst = 1'b1;
        clear_counts();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        for (int c = 0; c < 3; c++) begin
            case ($urandom_range(0, 3))
                0:       w[c*8 +: 8] = 8'h00;
                1:       w[c*8 +: 8] = 8'hFF;
                default: w[c*8 +: 8] = 8'($urandom);
            endcase
        end
        w[27:24] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        w[31]    = ($urandom_range(0, 7) != 0);
        return w;
    endfunction

    initial begin
        tests    = 0;
        fails    = 0;
        n        = 0;
        sh_a     = '0;
        sh_b     = '0;
        rst      = 1'b1;
        led_data = 32'h0;
        clear_counts();

        // Reset with full-on data: off during reset, full-on from the first period.
        do_reset(32'h80FF_FFFF);
        run(300);

        // Duty ratios and period_start rate.
        do_reset(32'h8040_80FF);
        run(255);
        clear_counts();
        run(255);
        check_eq("duty_r_low", a_r_low, 255);
        check_eq("duty_g_low", a_g_low, 128);
        check_eq("duty_b_low", a_b_low, 64);
        check_eq("period_start_cnt", a_ps_cnt, 1);

        // Extremes.
        do_reset(32'h8000_0000);
        run(300);
        check_eq("duty0_low", a_r_low + a_g_low + a_b_low, 0);

        // Mid-period write is deferred to the next boundary.
        do_reset(32'h8000_0010);
        run(255);
        clear_counts();
        run(100);
        led_data = 32'h8000_00F0;
        run(155);
        check_eq("midwr_cur_low", a_r_low, 16);
        clear_counts();
        run(255);
        check_eq("midwr_next_low", a_r_low, 240);

        // Blink sel=2: two periods on, two off.
        do_reset(32'h82FF_FFFF);
        run(255);
        clear_counts(); run(255); check_eq("blink_p1", a_r_low, 255);
        clear_counts(); run(255); check_eq("blink_p2", a_r_low, 0);
        clear_counts(); run(255); check_eq("blink_p3", a_g_low, 0);
        clear_counts(); run(255); check_eq("blink_p4", a_b_low, 255);
        led_data = 32'h80FF_FFFF;
        run(255);
        clear_counts();
        run(100);
        led_data = 32'h00FF_FFFF;
        run(155);
        check_eq("en_mid_low", a_r_low, 255);
        clear_counts();
        run(255);
        check_eq("en_off_low", a_r_low + a_g_low + a_b_low, 0);

        // Prescale 3, active-high: duty 2 -> 6 clks high per 765-clk period.
        do_reset(32'h8000_0002);
        run(765);
        clear_counts();
        run(765);
        check_eq("pre3_r_high", b_r_high, 6);

        // Randomized traffic with an unannounced mid-run reset.
        do_reset(rand_word());
        for (int i = 0; i < 24000; i++) begin
            step();
            if ($urandom_range(0, 63) == 0) led_data = rand_word();
            if (i == 11000) do_reset(rand_word());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
